tz80_sram_bridge: RTL and testbench
===================================

Name: tz80_sram_bridge

Overview:
- Memory-side responder for the tz80 CPU bus (address, o_data, we in; i_data, locked out).
- Replaces the zero-wait block-RAM controller with an external asynchronous 8-bit SRAM that needs wait states.
- Stalls the CPU through `locked` while an SRAM cycle is in flight.
- Serves repeated reads of the same address from a one-entry holding register, so they do not stall.

Parameters:
- WAIT_STATES, 2: extra SRAM access cycles beyond one. Range 0..15.
- SRAM_ADDR_W, 16: SRAM address width. Must be 16 or more; bits above 15 are driven 0.

Ports:
- clock  in  1  system clock, same net as the CPU clock
- reset  in  1  asynchronous, active-high
- address  in  16  CPU byte address
- o_data  in  8  CPU write data
- we  in  1  CPU write strobe, level
- i_data  out  8  read data to CPU, registered
- locked  out  1  1 = CPU may advance; 0 = stall
- sram_addr  out  SRAM_ADDR_W  SRAM address, registered
- sram_dq_o  out  8  SRAM write data
- sram_dq_i  in  8  SRAM read data
- sram_dq_oe  out  1  data bus output enable
- sram_ce_n  out  1  chip enable, active-low
- sram_oe_n  out  1  output enable, active-low
- sram_we_n  out  1  write enable, active-low

Behaviour:
- One clock; reset is asynchronous and active-high. Signal names: clock, reset.
- Reset values:
  - state=IDLE, valid=0, hold_addr=0, hold_data=0, i_data=0, wait counter=0.
  - sram_ce_n=1, sram_oe_n=1, sram_we_n=1, sram_dq_oe=0, sram_addr=0, sram_dq_o=0.
  - locked=0.
- Reset mid-access: the SRAM strobes deassert immediately (asynchronously). The access is abandoned and valid is cleared.
- hit = valid && address==hold_addr && !we.
- locked is combinational:
  - 1 in IDLE when hit.
  - 1 in DONE.
  - 0 otherwise.
- i_data always equals hold_data.
- States: IDLE, RD, WSETUP, WPULSE, WHOLD, DONE.
- IDLE:
  - hit: stay in IDLE; no SRAM activity.
  - we=1: latch hold_addr=address and hold_data=o_data, set valid=1, drive sram_addr and sram_dq_o; go to WSETUP.
  - else (read miss): latch hold_addr=address, clear valid, drive sram_addr; go to RD.
- RD:
  - ce_n=0, oe_n=0.
  - Lasts WAIT_STATES+1 cycles.
  - On the last cycle: hold_data<=sram_dq_i, valid<=1, go to DONE.
- WSETUP: ce_n=0, dq_oe=1, we_n=1; 1 cycle.
- WPULSE: ce_n=0, dq_oe=1, we_n=0; lasts WAIT_STATES+1 cycles.
- WHOLD: ce_n=0, dq_oe=1, we_n=1; 1 cycle.
- DONE:
  - Strobes inactive, locked=1 for exactly 1 cycle, then go to IDLE.
  - The CPU's next request is evaluated in IDLE on the following cycle.
- Latency, counted from cycle 0 (IDLE sees the request):
  - Read miss: locked=1 at cycle WAIT_STATES+2.
  - Write: locked=1 at cycle WAIT_STATES+4.
  - Hit: locked=1 in cycle 0.
- Boundaries:
  - A write to hold_addr is never a hit. It always performs the SRAM cycle and updates hold_data (write-through).
  - Changes on address, o_data or we while state != IDLE are ignored; the latched values are used.
  - WAIT_STATES=0 gives RD and WPULSE a duration of 1 cycle.
  - The wait counter width is 4 bits. It reloads on entry to RD/WPULSE and counts down to 0.
- The SRAM data bus is never driven while sram_oe_n=0.

Decomposition:
- Shared package tz80_bus_pkg contains:
  - the state enum;
  - WAIT_STATES_DEFAULT=2;
  - the CPU bus widths (ADDR_W=16, DATA_W=8).
- No sub-module; the wait counter and FSM stay inline.
- The tz80 bench instantiates this block plus a behavioural async-SRAM model with a programmable access time.

Test Plan:
- Reset: assert reset mid-WPULSE (WAIT_STATES=2) -> sram_we_n=1, sram_dq_oe=0 in the same timestep. After release, locked=0 and a read of 0x0000 misses.
- Read miss: SRAM[0x1234]=0xA5, address=0x1234, we=0 -> sram_ce_n/oe_n low for 3 cycles. At cycle 4, locked=1 and i_data=0xA5.
- Read hit: hold address 0x1234 after the miss -> locked=1 every cycle, sram_ce_n stays 1, i_data=0xA5.
- Write: address=0x0100, o_data=0x3C, we=1 -> WSETUP 1, we_n low 3, WHOLD 1 cycles. locked=1 at cycle 6; SRAM[0x0100]=0x3C. A following read of 0x0100 hits with i_data=0x3C.
- Address change while stalled: address=0x2000 (read miss), switch to 0x2001 at cycle 1 -> sram_addr stays 0x2000 and DONE returns SRAM[0x2000]. Next IDLE misses on 0x2001.
- WAIT_STATES=0: read miss -> locked=1 at cycle 2. Write -> locked=1 at cycle 4, sram_we_n low for exactly 1 cycle.

Source files
------------

// File: rtl/tz80_bus_pkg.sv
// tz80_bus_pkg: shared tz80 CPU bus widths and SRAM bridge state encoding
package tz80_bus_pkg;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  localparam int WAIT_STATES_DEFAULT = 2;
  typedef enum logic [2:0] {IDLE, RD, WSETUP, WPULSE, WHOLD, DONE} state_t;
endpackage

// File: rtl/tz80_sram_bridge_if.sv
// tz80_sram_bridge_if: tz80 CPU memory bus, CPU as master, memory as slave
interface tz80_sram_bridge_if;
  import tz80_bus_pkg::*;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] o_data;
  logic              we;
  logic [DATA_W-1:0] i_data;
  logic              locked;
  modport master (output address, o_data, we, input i_data, locked);
  modport slave (input address, o_data, we, output i_data, locked);
endinterface

// File: rtl/tz80_sram_bridge.sv
// tz80_sram_bridge: tz80 bus responder driving an async 8-bit SRAM with wait states
module tz80_sram_bridge
  import tz80_bus_pkg::*;
#(
  parameter int WAIT_STATES = WAIT_STATES_DEFAULT,
  parameter int SRAM_ADDR_W = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  tz80_sram_bridge_if.slave      bus,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0]      sram_dq_o,
  input  logic [DATA_W-1:0]      sram_dq_i,
  output logic                   sram_dq_oe,
  output logic                   sram_ce_n,
  output logic                   sram_oe_n,
  output logic                   sram_we_n
);
  localparam logic [3:0] WS = 4'(WAIT_STATES);
  state_t            state, state_nxt;
  logic              valid;
  logic [ADDR_W-1:0] hold_addr;
  logic [DATA_W-1:0] hold_data;
  logic [3:0]        cnt;
  logic              hit;
  assign hit = valid && bus.address == hold_addr && !bus.we;
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = hit ? IDLE : bus.we ? WSETUP : RD;
      RD:      state_nxt = cnt == '0 ? DONE : RD;
      WSETUP:  state_nxt = WPULSE;
      WPULSE:  state_nxt = cnt == '0 ? WHOLD : WPULSE;
      WHOLD:   state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end
  // strobes decode straight from state so reset releases them without waiting for a clock
  always_comb begin
    sram_ce_n  = !(state inside {RD, WSETUP, WPULSE, WHOLD});
    sram_oe_n  = state != RD;
    sram_we_n  = state != WPULSE;
    sram_dq_oe = state inside {WSETUP, WPULSE, WHOLD};
    bus.locked = (state == IDLE && hit) || state == DONE;
  end
  assign bus.i_data = hold_data;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      valid     <= 1'b0;
      hold_addr <= '0;
      hold_data <= '0;
      cnt       <= '0;
      sram_addr <= '0;
      sram_dq_o <= '0;
    end else begin
      case (state)
        IDLE: if (!hit) begin
          hold_addr <= bus.address;
          sram_addr <= SRAM_ADDR_W'(bus.address);
          valid     <= bus.we;
          cnt       <= WS;
          if (bus.we) begin
            hold_data <= bus.o_data;
            sram_dq_o <= bus.o_data;
          end
        end
        RD: if (cnt == '0) begin
          hold_data <= sram_dq_i;
          valid     <= 1'b1;
        end else cnt <= cnt - 4'd1;
        WSETUP: cnt <= WS;
        WPULSE: if (cnt != '0) cnt <= cnt - 4'd1;
        default: ;
      endcase
    end
endmodule

// File: tb/tb_tz80_sram_bridge.sv
// tb_tz80_sram_bridge: table, hand-written and random checks of the bridge at 2 and 0 wait states
module tb_tz80_sram_bridge;
  import tz80_bus_pkg::*;
  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
    logic        w;
    logic [15:0] a2;
    int          lat;
    logic [7:0]  ed;
  } vec_t;
  logic clk, reset, sel;
  logic [15:0] address;
  logic [7:0] o_data;
  logic we;
  int n_chk = 0, n_fail = 0;
  tz80_sram_bridge_if bus2();
  tz80_sram_bridge_if bus0();
  assign bus2.address = address;
  assign bus2.o_data = o_data;
  assign bus2.we = we;
  assign bus0.address = address;
  assign bus0.o_data = o_data;
  assign bus0.we = we;
  logic [15:0] sa2;
  logic [17:0] sa0;
  logic [7:0] dqo2, dqo0, dqi2, dqi0;
  logic dq_oe2, ce_n2, oe_n2, we_n2, dq_oe0, ce_n0, oe_n0, we_n0;
  tz80_sram_bridge #(.WAIT_STATES(2), .SRAM_ADDR_W(16)) dut2 (
    .clock(clk), .reset(reset), .bus(bus2), .sram_addr(sa2), .sram_dq_o(dqo2),
    .sram_dq_i(dqi2), .sram_dq_oe(dq_oe2), .sram_ce_n(ce_n2), .sram_oe_n(oe_n2), .sram_we_n(we_n2));
  tz80_sram_bridge #(.WAIT_STATES(0), .SRAM_ADDR_W(18)) dut0 (
    .clock(clk), .reset(reset), .bus(bus0), .sram_addr(sa0), .sram_dq_o(dqo0),
    .sram_dq_i(dqi0), .sram_dq_oe(dq_oe0), .sram_ce_n(ce_n0), .sram_oe_n(oe_n0), .sram_we_n(we_n0));
  logic [7:0] ref_mem[65536], mem2[65536], mem0[65536];
  assign dqi2 = (!ce_n2 && !oe_n2) ? mem2[sa2] : 8'h00;
  assign dqi0 = (!ce_n0 && !oe_n0) ? mem0[sa0[15:0]] : 8'h00;
  always @(posedge we_n2) if (!ce_n2 && dq_oe2) mem2[sa2] = dqo2;
  always @(posedge we_n0) if (!ce_n0 && dq_oe0) mem0[sa0[15:0]] = dqo0;
  logic locked, dq_oe, ce_n, oe_n, we_n;
  logic [7:0] i_data, dq_o;
  logic [15:0] s_addr;
  assign locked = sel ? bus0.locked : bus2.locked;
  assign i_data = sel ? bus0.i_data : bus2.i_data;
  assign dq_o = sel ? dqo0 : dqo2;
  assign s_addr = sel ? sa0[15:0] : sa2;
  assign dq_oe = sel ? dq_oe0 : dq_oe2;
  assign ce_n = sel ? ce_n0 : ce_n2;
  assign oe_n = sel ? oe_n0 : oe_n2;
  assign we_n = sel ? we_n0 : we_n2;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  logic mvalid;
  logic [15:0] maddr;
  logic [7:0] mdata;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask
  // one-entry cache of the last address plus a flat memory image
  task automatic predict(input logic [15:0] a, input logic [7:0] d, input logic w,
                         output int lat, output logic [7:0] ed);
    int ws;
    ws = sel ? 0 : 2;
    if (mvalid && a == maddr && !w) begin
      lat = 0;
      ed = mdata;
    end else begin
      if (w) ref_mem[a] = d;
      lat = ws + (w ? 4 : 2);
      ed = ref_mem[a];
      mvalid = 1'b1;
      maddr = a;
      mdata = ed;
    end
  endtask
  task automatic xact(input logic [15:0] a, input logic [7:0] d, input logic w,
                      input logic [15:0] a2, input int elat, input logic [7:0] ed);
    int n, ce, oe, wl, ws;
    ws = sel ? 0 : 2;
    n = 0; ce = 0; oe = 0; wl = 0;
    address = a; o_data = d; we = w;
    #1;
    while (!locked && n < 40) begin
      if (!ce_n) ce++;
      if (!oe_n) oe++;
      if (!we_n) wl++;
      chk("bus_contention", {31'b0, !oe_n && dq_oe}, 0);
      if (!we_n) chk("wr_data", dq_o, d);
      @(negedge clk);
      n++;
      if (n == 1) begin
        chk("sram_addr", s_addr, a);
        if (sel) chk("sram_addr_hi", sa0[17:16], 0);
        address = a2; o_data = 8'($urandom); we = 1'($urandom);
      end
      #1;
    end
    chk("latency", n, elat);
    chk("i_data", i_data, ed);
    chk("done_strobes", {ce_n, oe_n, we_n, dq_oe}, 4'b1110);
    chk("ce_cycles", ce, elat == 0 ? 0 : elat - 1);
    chk("oe_cycles", oe, (elat != 0 && !w) ? ws + 1 : 0);
    chk("we_cycles", wl, w ? ws + 1 : 0);
    @(negedge clk);
  endtask
  task automatic rand_xact();
    logic [15:0] a;
    logic [7:0] d, ed;
    logic w;
    int lat;
    a = ($urandom_range(0, 1) == 1) ? maddr : 16'($urandom_range(0, 7)) * 16'h0101;
    w = $urandom_range(0, 3) == 0;
    d = 8'($urandom);
    predict(a, d, w, lat, ed);
    xact(a, d, w, 16'($urandom), lat, ed);
  endtask
  initial begin
    vec_t tv[10];
    int lat;
    logic [7:0] ed;
    tv[0] = '{16'h1234, 8'h00, 1'b0, 16'h1234, 4, 8'hA5};
    tv[1] = '{16'h1234, 8'h00, 1'b0, 16'h1234, 0, 8'hA5};
    tv[2] = '{16'h1234, 8'hFF, 1'b0, 16'h1234, 0, 8'hA5};
    tv[3] = '{16'h0100, 8'h3C, 1'b1, 16'h0100, 6, 8'h3C};
    tv[4] = '{16'h0100, 8'h00, 1'b0, 16'h0100, 0, 8'h3C};
    tv[5] = '{16'h0100, 8'h77, 1'b1, 16'h0100, 6, 8'h77};
    tv[6] = '{16'h0100, 8'h00, 1'b0, 16'h0100, 0, 8'h77};
    tv[7] = '{16'h2000, 8'h00, 1'b0, 16'h2001, 4, 8'h5A};
    tv[8] = '{16'h2001, 8'h00, 1'b0, 16'h2001, 4, 8'hC3};
    tv[9] = '{16'h2001, 8'h00, 1'b0, 16'h2001, 0, 8'hC3};
    for (int i = 0; i < 65536; i++) ref_mem[i] = 8'(i * 7 + 3);
    ref_mem[16'h0000] = 8'h11;
    ref_mem[16'h1234] = 8'hA5;
    ref_mem[16'h2000] = 8'h5A;
    ref_mem[16'h2001] = 8'hC3;
    for (int i = 0; i < 65536; i++) begin
      mem2[i] = ref_mem[i];
      mem0[i] = ref_mem[i];
    end
    mvalid = 1'b0; maddr = '0; mdata = '0;
    sel = 1'b0; reset = 1'b1; address = '0; o_data = 8'h11; we = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_locked", {31'b0, locked}, 0);
    chk("rst_strobes", {ce_n, oe_n, we_n, dq_oe}, 4'b1110);
    chk("rst_i_data", i_data, 0);
    chk("rst_sram_addr", s_addr, 0);
    chk("rst_dq_o", dq_o, 0);
    // the abandoned write carries the byte already stored, so its fate does not matter
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 chk("wpulse_we_n", {31'b0, we_n}, 0);
    reset = 1'b1;
    #1 chk("rst_mid_wpulse", {ce_n, we_n, dq_oe}, 3'b110);
    @(negedge clk);
    reset = 1'b0; we = 1'b0;
    #1 chk("post_rst_locked", {31'b0, locked}, 0);
    predict(16'h0000, 8'h00, 1'b0, lat, ed);
    xact(16'h0000, 8'h00, 1'b0, 16'h0000, lat, ed);
    for (int i = 0; i < 10; i++) begin
      predict(tv[i].a, tv[i].d, tv[i].w, lat, ed);
      xact(tv[i].a, tv[i].d, tv[i].w, tv[i].a2, tv[i].lat, tv[i].ed);
    end
    for (int i = 0; i < 150; i++) rand_xact();
    reset = 1'b1; sel = 1'b1; address = '0; we = 1'b0;
    mvalid = 1'b0; maddr = '0; mdata = '0;
    for (int i = 0; i < 65536; i++) mem0[i] = ref_mem[i];
    @(negedge clk);
    reset = 1'b0;
    xact(16'h1234, 8'h00, 1'b0, 16'h1234, 2, ref_mem[16'h1234]);
    predict(16'h1234, 8'h00, 1'b0, lat, ed);
    xact(16'h1234, 8'h00, 1'b0, 16'h1234, 0, ref_mem[16'h1234]);
    predict(16'h0100, 8'h96, 1'b1, lat, ed);
    xact(16'h0100, 8'h96, 1'b1, 16'h0100, 4, 8'h96);
    predict(16'h0100, 8'h00, 1'b0, lat, ed);
    xact(16'h0100, 8'h00, 1'b0, 16'h0100, 0, 8'h96);
    for (int i = 0; i < 100; i++) rand_xact();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
